// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word requests to imem, buffers
// in-order responses in a small FIFO and presents {inst, pc} to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] DEPTH_U  = FIFO_DEPTH;
  localparam logic [31:0] MAX_OS_U = MAX_OUTSTANDING;

  logic          run_q, run_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   inst_mem_q [FIFO_DEPTH];
  logic [31:0]   inst_mem_d [FIFO_DEPTH];
  logic [31:0]   pc_mem_q   [FIFO_DEPTH];
  logic [31:0]   pc_mem_d   [FIFO_DEPTH];

  logic        pop;
  logic        push;
  logic        req_fire;
  logic [31:0] slots_used;
  logic [31:0] redirect_pc_al;
  logic        redirect_pc_unused;

  assign redirect_pc_al     = {redirect_pc[31:2], 2'b00};
  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign if_valid      = (cnt_q != '0);
  assign if_inst       = inst_mem_q[rd_ptr_q];
  assign if_pc         = pc_mem_q[rd_ptr_q];
  assign imem_req_addr = pc_q;

  assign pop = if_valid && if_ready;

  // A head popped this cycle frees its slot, which keeps the pipe full at
  // one instruction per cycle with single-cycle memory.
  assign slots_used = 32'(cnt_q) + 32'(outst_q) - 32'(drop_q) - {31'b0, pop};

  assign imem_req_valid = run_q && !redirect_valid
                          && (32'(outst_q) < MAX_OS_U)
                          && (slots_used < DEPTH_U);
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push     = imem_resp_valid && (drop_q == '0) && !redirect_valid;

  always_comb begin
    run_d      = 1'b1;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    outst_d    = outst_q + OW'(req_fire) - OW'(imem_resp_valid);

    if (req_fire) pc_d = pc_q + 32'd4;

    if (redirect_valid) begin
      // No request goes out this cycle, so every remaining outstanding
      // response belongs to the old stream.
      pc_d      = redirect_pc_al;
      resp_pc_d = redirect_pc_al;
      drop_d    = outst_d;
      cnt_d     = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - OW'(1'b1);
      if (push) begin
        inst_mem_d[wr_ptr_q] = imem_resp_data;
        pc_mem_d[wr_ptr_q]   = resp_pc_q;
        wr_ptr_d             = wr_ptr_q + AW'(1'b1);
        resp_pc_d            = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1'b1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inst_mem_q <= '{default: '0};
      pc_mem_q   <= '{default: '0};
    end else begin
      run_q      <= run_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  a_resp_has_req: assert property (@(posedge clk) disable iff (!reset_n)
    imem_resp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order variable-latency imem model,
// expected {pc, inst} queue popped by a monitor on every decode handshake.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;

  logic [31:0] exp_pc[$];
  logic [31:0] exp_inst[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  int          pop_cyc[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    logic [31:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      exp_pc.push_back(a);
      exp_inst.push_back(inst_of(a));
      a = a + 32'd4;
    end
  endtask

  task automatic mem_sample();
    forever begin
      @(negedge clk);
      if (reset_n && imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic mem_drive();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (!reset_n) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (pend_due.size() != 0 && pend_due[0] == cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = inst_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
  endtask

  task automatic monitor();
    logic [31:0] ep, ei;
    forever begin
      @(negedge clk);
      if (reset_n && if_valid && if_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_pc.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc=%h inst=%h, required no delivery", if_pc, if_inst);
        end else begin
          ep = exp_pc.pop_front();
          ei = exp_inst.pop_front();
          check("sb_if_pc", if_pc, ep);
          check("sb_if_inst", if_inst, ei);
        end
      end
    end
  endtask

  task automatic do_reset(input int l, input logic rdy);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    tick(2);
    exp_pc.delete();
    exp_inst.delete();
    req_log.delete();
    req_cyc.delete();
    pop_cyc.delete();
    lat      = l;
    reset_n  = 1'b1;
    if_ready = rdy;
  endtask

  // Returns at the start of the cycle following the first accepted request.
  task automatic wait_first_req();
    int n;
    n = 0;
    while (req_log.size() == 0 && n < 10) begin
      tick(1);
      n++;
    end
    check("first_req_seen", 32'(req_log.size() != 0), 32'd1);
  endtask

  initial begin
    reset_n         = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    if_ready        = 1'b0;
    fork
      mem_sample();
      mem_drive();
      monitor();
    join_none

    // reset state
    tick(2);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);

    // straight-line fetch, 1-cycle memory
    do_reset(1, 1'b1);
    push_seq(32'h0, 40);
    wait_first_req();
    tick(18);
    check("t1_req_count", 32'(req_log.size() >= 6), 32'd1);
    if (req_log.size() >= 6)
      for (int i = 0; i < 6; i++) check("t1_req_addr", req_log[i], 32'(4 * i));
    check("t1_pop_count", 32'(pop_cyc.size() >= 15), 32'd1);
    if (pop_cyc.size() >= 15 && req_cyc.size() >= 1) begin
      check("t1_fill_latency", 32'(pop_cyc[0] - req_cyc[0]), 32'd2);
      for (int i = 1; i < 15; i++) check("t1_one_per_cycle", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
    end

    // backpressure
    do_reset(1, 1'b0);
    push_seq(32'h0, 40);
    wait_first_req();
    tick(4);
    check("t2_if_valid", 32'(if_valid), 32'd1);
    check("t2_hold_pc_a", if_pc, 32'h0);
    check("t2_hold_inst_a", if_inst, inst_of(32'h0));
    tick(6);
    check("t2_in_flight", 32'(req_log.size()), 32'd2);
    check("t2_hold_pc_b", if_pc, 32'h0);
    check("t2_hold_inst_b", if_inst, inst_of(32'h0));
    if_ready = 1'b1;
    tick(10);
    check("t2_pop_count", 32'(pop_cyc.size() >= 8), 32'd1);
    if (req_log.size() >= 8)
      for (int i = 0; i < 8; i++) check("t2_req_addr", req_log[i], 32'(4 * i));

    // redirect with two outstanding, 3-cycle memory
    do_reset(3, 1'b1);
    push_seq(32'h100, 20);
    wait_first_req();
    tick(1);
    check("t3_max_outstanding", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check("t3_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    check("t3_if_valid_after", 32'(if_valid), 32'd0);
    tick(25);
    check("t3_req_target", req_log[2], 32'h100);
    check("t3_req_next", req_log[3], 32'h104);
    check("t3_pop_count", 32'(pop_cyc.size() >= 5), 32'd1);

    // redirect coincident with response arrival and head pop
    do_reset(1, 1'b1);
    push_seq(32'h0, 4);
    push_seq(32'h200, 30);
    wait_first_req();
    tick(4);
    check("t4_head_before", if_pc, 32'hC);
    check("t4_resp_arriving", 32'(imem_resp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    check("t4_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    check("t4_if_valid_after", 32'(if_valid), 32'd0);
    tick(12);
    check("t4_req_last_old", req_log[4], 32'h10);
    check("t4_req_target", req_log[5], 32'h200);
    check("t4_pop_count", 32'(pop_cyc.size() >= 12), 32'd1);

    // back-to-back redirects while old responses are still being dropped
    do_reset(3, 1'b1);
    push_seq(32'h300, 20);
    wait_first_req();
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick(1);
    redirect_pc    = 32'h300;
    tick(1);
    redirect_valid = 1'b0;
    check("t5_if_valid_after", 32'(if_valid), 32'd0);
    tick(25);
    check("t5_req_target", req_log[2], 32'h300);
    check("t5_req_next", req_log[3], 32'h304);
    check("t5_pop_count", 32'(pop_cyc.size() >= 5), 32'd1);

    // PC wrap
    do_reset(1, 1'b1);
    push_seq(32'hFFFF_FFF8, 20);
    wait_first_req();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    #1;
    check("t6_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    check("t6_if_valid_after", 32'(if_valid), 32'd0);
    tick(12);
    check("t6_req0", req_log[0], 32'h0);
    check("t6_req1", req_log[1], 32'hFFFF_FFF8);
    check("t6_req2", req_log[2], 32'hFFFF_FFFC);
    check("t6_req3", req_log[3], 32'h0000_0000);
    check("t6_req4", req_log[4], 32'h0000_0004);
    check("t6_pop_count", 32'(pop_cyc.size() >= 8), 32'd1);

    // asynchronous reset mid-burst
    do_reset(1, 1'b1);
    push_seq(32'h0, 40);
    wait_first_req();
    tick(5);
    #2;
    check("t7_busy_before", 32'(if_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t7_if_valid_drop", 32'(if_valid), 32'd0);
    check("t7_req_valid_drop", 32'(imem_req_valid), 32'd0);
    check("t7_if_inst_clr", if_inst, 32'd0);
    check("t7_if_pc_clr", if_pc, 32'd0);
    check("t7_req_addr_clr", imem_req_addr, RESET_PC);
    tick(2);
    exp_pc.delete();
    exp_inst.delete();
    req_log.delete();
    req_cyc.delete();
    pop_cyc.delete();
    push_seq(RESET_PC, 20);
    reset_n = 1'b1;
    wait_first_req();
    check("t7_first_req", req_log[0], RESET_PC);
    tick(10);
    check("t7_pop_count", 32'(pop_cyc.size() >= 8), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
